serial_xmtr_param: RTL and testbench
====================================

Name: serial_xmtr_param

Overview:
Parametrised serial transmitter; the next generation of the team's 8-bit load/ready/start transmitter. Accepts parallel words on a valid/ready handshake into a one-word holding register and shifts them out LSB-first as framed serial bits. Each frame is start bit, data bits, optional parity and 1 or 2 stop bits, and each bit lasts a programmable number of clocks. Double buffering allows back-to-back frames with no idle gap. The block sits between a parallel data source and the board-level serial pin.

Parameters:
WORD_SIZE, 8, data bits per frame (1..32).
CLKS_PER_BIT, 4, clock cycles per serial bit (>=1).
PARITY_MODE, 0, 0=none, 1=even, 2=odd.
STOP_BITS, 1, stop bits per frame (1 or 2).

Ports:
i_clk  input  1  system clock, rising edge.
i_reset  input  1  asynchronous reset, active-high.
i_data_bus  input  WORD_SIZE  word to transmit.
i_load_xmt_data  input  1  valid; a word is accepted on a rising edge where i_load_xmt_data=1 and o_ready=1.
o_ready  output  1  holding register empty.
i_tx_enable  input  1  permits starting a new frame.
o_serial_out  output  1  serial line; idle high; registered.
o_busy  output  1  frame in progress (state != IDLE).
o_done  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset (async, i_reset=1): o_serial_out=1, o_ready=1, o_busy=0, o_done=0, state IDLE; holding register, shift register and bit and clock counters are cleared. Asserting reset mid-frame aborts the frame immediately and discards any held word.
- Holding register: a handshake at edge k captures i_data_bus, and o_ready=0 after edge k. o_ready is driven directly from the holding-full flag. A valid pulse while o_ready=0 is ignored; the held word is not overwritten.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START: on an edge where the holding register is full and i_tx_enable=1.
  - The shift register loads the held word.
  - Parity is computed from that word: even mode gives XOR of the bits; odd mode gives its inverse.
  - The holding register is freed, so o_ready=1 after that edge.
  - o_serial_out=0 and o_busy=1 after that edge.
  - Start latency: handshake at edge k, first start-bit cycle follows edge k+1 (IDLE with enable high).
- Bit timing: every bit is held exactly CLKS_PER_BIT cycles by a clock counter counting 0..CLKS_PER_BIT-1.
- START -> DATA.
- DATA: emits WORD_SIZE bits LSB first, then goes to PARITY if PARITY_MODE!=0, else to STOP.
- PARITY -> STOP.
- STOP: o_serial_out=1 for STOP_BITS bit periods.
- Frame length: (1+WORD_SIZE+(PARITY_MODE!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
- End of the last stop bit:
  - o_done=1 for exactly one cycle, following the ending edge.
  - If the holding register is full and i_tx_enable=1, go directly to START on that edge with no idle cycle, and keep o_busy=1.
  - Otherwise go to IDLE with o_busy=0.
- i_tx_enable=0: blocks only IDLE->START and the back-to-back restart. A frame in progress always completes, and the held word is retained.
- Simultaneous handshake and holding-register release on the same edge: the new word is captured. o_ready depends on the registered full flag, so a handshake can only occur while the register is empty.
- PARITY_MODE values 3 and above behave as 0.

Test Plan:
1. Reset: WORD_SIZE=8, CLKS_PER_BIT=4, PARITY_MODE=1, STOP_BITS=1. Pulse i_reset, then load 0xA5 -> o_ready=1, o_serial_out=1, o_busy=0 during reset. Afterwards the line carries 0 then 1,0,1,0,0,1,0,1, then parity 0, then stop 1, each bit 4 cycles (44 cycles total). o_done pulses once at cycle 44.
2. Odd parity instance (PARITY_MODE=2), load 0x07 -> parity bit 0. Same word with PARITY_MODE=1 -> parity bit 1. PARITY_MODE=0, STOP_BITS=2 -> frame is 44 cycles with no parity bit and stop high for 8 cycles.
3. Back-to-back: load 0x01, then load 0xFF as soon as o_ready=1 -> the second start bit begins exactly 44 cycles after the first, with no idle-high cycle between frames. o_busy stays 1 across both frames, and o_done pulses twice.
4. Overrun: while the holding register is full, pulse i_load_xmt_data with 0x3C -> the word is ignored, and the originally held word is sent.
5. Enable gating: hold i_tx_enable=0, load 0x55 -> o_serial_out stays 1 and o_ready=0 indefinitely. Raise enable -> the start bit begins one cycle later. Drop enable mid-frame -> the frame completes.
6. Reset mid-frame: assert i_reset during data bit 3 -> o_serial_out=1 immediately (asynchronous), o_ready=1, o_busy=0. After release, a new word 0x81 transmits correctly.

Source files
------------

// File: rtl/serial_xmtr_param.sv
// serial_xmtr_param
//   Parametrised framed serial transmitter. A parallel word is accepted on a
//   valid/ready handshake into a one-word holding register. The word is then
//   shifted out LSB-first as: start bit (0), WORD_SIZE data bits, an optional
//   parity bit, and STOP_BITS stop bits (1). Each bit lasts CLKS_PER_BIT clocks.
//   Because the holding register is separate from the shift register, a word
//   can wait while a frame is in flight. That word starts on the very edge that
//   ends the previous frame, so back-to-back frames have no idle gap.
//
// Parameters
//   WORD_SIZE     data bits per frame (1..32)
//   CLKS_PER_BIT  clocks per serial bit (>=1)
//   PARITY_MODE   0 none, 1 even, 2 odd, any other value behaves as none
//   STOP_BITS     stop bits per frame (1 or 2)
//
// Ports
//   i_clk            system clock, rising edge
//   i_reset          asynchronous active-high reset
//   i_data_bus       word to transmit
//   i_load_xmt_data  valid; word accepted when high while o_ready is high
//   o_ready          holding register empty
//   i_tx_enable      permits starting a new frame
//   o_serial_out     registered serial line, idle high
//   o_busy           frame in progress
//   o_done           one-cycle pulse after the edge that ends a frame
module serial_xmtr_param #(
  parameter int WORD_SIZE    = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [WORD_SIZE-1:0] i_data_bus,
  input  logic                 i_load_xmt_data,
  output logic                 o_ready,
  input  logic                 i_tx_enable,
  output logic                 o_serial_out,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (WORD_SIZE > 2) ? $clog2(WORD_SIZE) : 1;
  localparam bit HAS_PARITY = (PARITY_MODE == 1) || (PARITY_MODE == 2);
  localparam bit ODD_PARITY = (PARITY_MODE == 2);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(WORD_SIZE - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_SIZE-1:0] shift_q, shift_d;
  logic [WORD_SIZE-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 parity_q, parity_d;
  logic                 serial_q, serial_d;
  logic                 done_q, done_d;

  logic bit_end;
  logic last_data;
  logic last_stop;
  logic start_ok;
  logic frame_load;

  assign bit_end   = (clk_cnt_q == CNT_LAST);
  assign last_data = (bit_cnt_q == DATA_LAST);
  assign last_stop = (bit_cnt_q == STOP_LAST);
  assign start_ok  = hold_full_q && i_tx_enable;

  // State register and all datapath flops
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      parity_q    <= 1'b0;
      serial_q    <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      parity_q    <= parity_d;
      serial_q    <= serial_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start_ok) state_d = ST_START;
      ST_START:  if (bit_end) state_d = ST_DATA;
      ST_DATA:   if (bit_end && last_data) state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP:   if (bit_end && last_stop) state_d = start_ok ? ST_START : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // A frame begins whenever START is entered from another state. START always
  // lasts a whole bit, so START->START never happens.
  assign frame_load = (state_d == ST_START) && (state_q != ST_START);

  // Datapath and output logic
  always_comb begin
    clk_cnt_d   = (state_q == ST_IDLE || bit_end) ? '0 : clk_cnt_q + CNT_W'(1);
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    done_d      = (state_q == ST_STOP) && bit_end && last_stop;

    // The bit counter is reused to count data bits and stop bits.
    if (state_q == ST_IDLE) begin
      bit_cnt_d = '0;
    end else if (bit_end) begin
      if ((state_q == ST_DATA && !last_data) || (state_q == ST_STOP && !last_stop))
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
      else
        bit_cnt_d = '0;
    end

    if (frame_load) begin
      shift_d     = hold_q;
      parity_d    = (^hold_q) ^ ODD_PARITY;
      hold_full_d = 1'b0;
    end else if (state_q == ST_DATA && bit_end && !last_data) begin
      shift_d = shift_q >> 1;
    end

    // frame_load requires a full register and a handshake requires an empty
    // one, so the two never collide on the same edge.
    if (i_load_xmt_data && !hold_full_q) begin
      hold_d      = i_data_bus;
      hold_full_d = 1'b1;
    end

    // The line is registered, so it is driven from the state being entered.
    unique case (state_d)
      ST_START:  serial_d = 1'b0;
      ST_DATA:   serial_d = shift_d[0];
      ST_PARITY: serial_d = parity_d;
      default:   serial_d = 1'b1;
    endcase
  end

  assign o_ready      = !hold_full_q;
  assign o_serial_out = serial_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_done       = done_q;

endmodule

// File: tb/tb_serial_xmtr_param.sv
// tb_serial_xmtr_param
//   Drives four differently parameterised transmitters from one shared stimulus
//   stream. Each instance is compared every cycle against a reference model.
//   The model expands each frame into a queue of per-cycle line values and pops
//   one value per clock. A directed 0xA5 frame is also checked against a
//   hand-written bit pattern, and reset is checked asynchronously mid-cycle.
module tb_serial_xmtr_param;

  localparam int NI = 4;
  localparam int CFG_W[NI] = '{8, 8, 8, 5};
  localparam int CFG_C[NI] = '{4, 4, 4, 1};
  localparam int CFG_P[NI] = '{1, 2, 0, 3};
  localparam int CFG_S[NI] = '{1, 1, 2, 2};

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic        en;
  logic [31:0] data;
  wire  [NI-1:0] ser_w;
  wire  [NI-1:0] busy_w;
  wire  [NI-1:0] ready_w;
  wire  [NI-1:0] done_w;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_inst
      localparam int W  = CFG_W[gi];
      localparam int C  = CFG_C[gi];
      localparam int P  = CFG_P[gi];
      localparam int S  = CFG_S[gi];

      serial_xmtr_param #(
        .WORD_SIZE(W), .CLKS_PER_BIT(C), .PARITY_MODE(P), .STOP_BITS(S)
      ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_data_bus(data[W-1:0]),
        .i_load_xmt_data(load),
        .o_ready(ready_w[gi]),
        .i_tx_enable(en),
        .o_serial_out(ser_w[gi]),
        .o_busy(busy_w[gi]),
        .o_done(done_w[gi])
      );

      // Reference model: one queue entry per remaining cycle of the frame.
      bit          q[$];
      bit          m_full = 1'b0;
      bit          m_busy = 1'b0;
      bit          e_ser  = 1'b1;
      bit          e_done = 1'b0;
      logic [31:0] m_word = '0;

      always @(posedge clk or posedge rst) begin
        bit ending, was_full, par;
        if (rst) begin
          q.delete();
          m_full = 1'b0;
          m_busy = 1'b0;
          e_ser  = 1'b1;
          e_done = 1'b0;
          m_word = '0;
        end else begin
          ending   = m_busy && (q.size() == 0);
          was_full = m_full;
          e_done   = ending;
          if (m_full && en && (!m_busy || ending)) begin
            q.delete();
            for (int k = 0; k < C; k++) q.push_back(1'b0);
            for (int b = 0; b < W; b++)
              for (int k = 0; k < C; k++) q.push_back(m_word[b]);
            if (P == 1 || P == 2) begin
              par = 1'b0;
              for (int b = 0; b < W; b++) par = par ^ m_word[b];
              if (P == 2) par = !par;
              for (int k = 0; k < C; k++) q.push_back(par);
            end
            for (int k = 0; k < S * C; k++) q.push_back(1'b1);
            e_ser  = q.pop_front();
            m_busy = 1'b1;
            m_full = 1'b0;
          end else if (m_busy && q.size() != 0) begin
            e_ser = q.pop_front();
          end else begin
            e_ser  = 1'b1;
            m_busy = 1'b0;
          end
          if (load && !was_full) begin
            m_full = 1'b1;
            m_word = data;
          end
        end
      end

      always @(negedge clk) begin
        check_value($sformatf("i%0d_ser", gi), 64'(ser_w[gi]), 64'(e_ser));
        check_value($sformatf("i%0d_busy", gi), 64'(busy_w[gi]), 64'(m_busy));
        check_value($sformatf("i%0d_ready", gi), 64'(ready_w[gi]), 64'(!m_full));
        check_value($sformatf("i%0d_done", gi), 64'(done_w[gi]), 64'(e_done));
      end
    end
  endgenerate

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_word(input logic [31:0] w);
    load = 1'b1;
    data = w;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Reset asserted between edges; outputs must react before any clock edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      check_value($sformatf("%s_ser%0d", tag, i), 64'(ser_w[i]), 64'd1);
      check_value($sformatf("%s_busy%0d", tag, i), 64'(busy_w[i]), 64'd0);
      check_value($sformatf("%s_ready%0d", tag, i), 64'(ready_w[i]), 64'd1);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [10:0] pat;
    logic [43:0] seen, expv;
    int          done_seen;

    rst  = 1'b1;
    load = 1'b1;
    data = 32'hA5;
    en   = 1'b1;
    cycles(3);
    rst  = 1'b0;
    load = 1'b0;
    cycles(2);

    // Directed 0xA5 frame on the even-parity instance: start, A5 LSB-first,
    // parity 0, stop; 4 cycles per bit.
    pat = {1'b1, 1'b0, 8'hA5, 1'b0};
    for (int c = 0; c < 44; c++) expv[c] = pat[c / 4];
    load_word(32'hA5);
    done_seen = 0;
    for (int c = 0; c < 44; c++) begin
      @(negedge clk);
      seen[c] = ser_w[0];
      done_seen += int'(done_w[0]);
    end
    check_value("a5_line", 64'(seen), 64'(expv));
    check_value("a5_done_early", 64'(done_seen), 64'd0);
    @(negedge clk);
    check_value("a5_done_end", 64'(done_w[0]), 64'd1);
    cycles(10);

    // Parity of 0x07 on the even and odd instances
    load_word(32'h07);
    cycles(60);

    // Back-to-back frames, then overrun attempts with 0x3C while held
    load_word(32'h01);
    load = 1'b1;
    data = 32'hFF;
    cycles(10);
    data = 32'h3C;
    cycles(20);
    load = 1'b0;
    cycles(120);

    // Enable gating
    en = 1'b0;
    load_word(32'h55);
    cycles(80);
    en = 1'b1;
    cycles(20);
    en = 1'b0;
    cycles(80);
    en = 1'b1;
    cycles(60);

    // Reset during data bit 3, then a fresh word
    load_word(32'hC3);
    cycles(18);
    async_reset("mid_rst");
    load_word(32'h81);
    cycles(60);

    // Randomised traffic
    for (int n = 0; n < 2000; n++) begin
      load = ($urandom_range(0, 3) == 0);
      data = $urandom;
      en   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 399) == 0) async_reset("rnd_rst");
      else @(negedge clk);
    end
    load = 1'b0;
    en   = 1'b1;
    cycles(60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
